timer_peri: RTL and testbench

Memory-mapped 32-bit timer/compare peripheral on the core data bus, alongside the RAM controller and UART. It decodes four word registers in the peripheral address window, counts prescaled clock ticks, and raises a level interrupt on a compare match or an overflow. Read data returns on the shared bus with the same one-cycle registered `outEn` handshake as the other bus slaves.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_prescaler.sv | 33 +++
 rtl/timer_peri.sv | 124 ++++++++++++
 tb/tb_timer_peri.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer/compare bus peripheral.
// Register map, field bit positions and reset values.
package timer_pkg;

  localparam int XLEN_D  = 32;
  localparam int ADDRW_D = 11;

  localparam logic [10:0] TCR_ADDR_D  = 11'h404;
  localparam logic [10:0] TCNT_ADDR_D = 11'h405;
  localparam logic [10:0] TCMP_ADDR_D = 11'h406;
  localparam logic [10:0] TSR_ADDR_D  = 11'h407;

  localparam int TCR_EN  = 0;
  localparam int TCR_AR  = 1;
  localparam int TCR_MIE = 2;
  localparam int TCR_OIE = 3;
  localparam int TCR_PRE_LSB = 8;
  localparam int TCR_PRE_MSB = 15;

  localparam int TSR_MF = 0;
  localparam int TSR_OF = 1;

  localparam logic [31:0] TCR_MASK = 32'h0000_FF0F;
  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: pcnt runs 0..pre and emits one tick per wrap.
// Dropping en or shrinking pre below pcnt returns pcnt to 0.
module timer_prescaler (
  input  logic       clk,
  input  logic       rstB,
  input  logic       en,
  input  logic [7:0] pre,
  output logic       tick
);

  logic [7:0] pcnt_q;
  logic [7:0] pcnt_d;

  always_comb begin
    pcnt_d = '0;
    tick   = 1'b0;
    if (en) begin
      tick = (pcnt_q == pre);
      if (pcnt_q < pre) begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/timer_peri.sv
// Memory-mapped 32-bit timer with compare match and overflow irq.
// Registers TCR/TCNT/TCMP/TSR; registered one-cycle read return.
module timer_peri
  import timer_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int ADDRW = ADDRW_D,
  parameter logic [ADDRW-1:0] TCR_ADDR  = TCR_ADDR_D,
  parameter logic [ADDRW-1:0] TCNT_ADDR = TCNT_ADDR_D,
  parameter logic [ADDRW-1:0] TCMP_ADDR = TCMP_ADDR_D,
  parameter logic [ADDRW-1:0] TSR_ADDR  = TSR_ADDR_D
) (
  input  logic             clk,
  input  logic             rstB,
  input  logic [ADDRW-1:0] addr,
  input  logic [XLEN-1:0]  wrData,
  input  logic             wrEn,
  input  logic             rdEn,
  output logic [XLEN-1:0]  dataOut,
  output logic             outEn,
  output logic             irq
);

  logic [XLEN-1:0] tcr_q, tcr_d;
  logic [XLEN-1:0] tcnt_q, tcnt_d;
  logic [XLEN-1:0] tcmp_q, tcmp_d;
  logic            mf_q, mf_d;
  logic            of_q, of_d;
  logic [XLEN-1:0] dout_q, dout_d;
  logic            oen_q, oen_d;

  logic sel_tcr, sel_tcnt, sel_tcmp, sel_tsr, sel_any;
  logic en_eff, tick, hit, at_max;
  logic mf_set, of_set;
  logic [XLEN-1:0] rd_val;

  assign sel_tcr  = (addr == TCR_ADDR);
  assign sel_tcnt = (addr == TCNT_ADDR);
  assign sel_tcmp = (addr == TCMP_ADDR);
  assign sel_tsr  = (addr == TSR_ADDR);
  assign sel_any  = sel_tcr | sel_tcnt | sel_tcmp | sel_tsr;

  // Clearing EN stops the prescaler at the same edge as the write.
  assign en_eff = tcr_q[TCR_EN] & ~(wrEn & sel_tcr & ~wrData[TCR_EN]);

  timer_prescaler u_pre (
    .clk  (clk),
    .rstB (rstB),
    .en   (en_eff),
    .pre  (tcr_q[TCR_PRE_MSB:TCR_PRE_LSB]),
    .tick (tick)
  );

  assign hit    = (tcnt_q == tcmp_q);
  assign at_max = (tcnt_q == '1);

  always_comb begin
    tcnt_d = tcnt_q;
    mf_set = 1'b0;
    of_set = 1'b0;
    if (wrEn && sel_tcnt) begin
      tcnt_d = wrData;
    end else if (tick) begin
      mf_set = hit;
      of_set = at_max;
      tcnt_d = (hit && tcr_q[TCR_AR]) ? '0 : tcnt_q + 1'b1;
    end
  end

  always_comb begin
    tcr_d  = tcr_q;
    tcmp_d = tcmp_q;
    if (wrEn && sel_tcr) begin
      tcr_d = wrData & TCR_MASK;
    end
    if (wrEn && sel_tcmp) begin
      tcmp_d = wrData;
    end
    // A flag being set wins over a coincident W1C.
    mf_d = (mf_q & ~(wrEn & sel_tsr & wrData[TSR_MF])) | mf_set;
    of_d = (of_q & ~(wrEn & sel_tsr & wrData[TSR_OF])) | of_set;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_tcr:  rd_val = tcr_q;
      sel_tcnt: rd_val = tcnt_q;
      sel_tcmp: rd_val = tcmp_q;
      sel_tsr:  rd_val = {{(XLEN-2){1'b0}}, of_q, mf_q};
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    oen_d  = rdEn & sel_any;
    dout_d = oen_d ? rd_val : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      tcr_q  <= '0;
      tcnt_q <= '0;
      tcmp_q <= TCMP_RST;
      mf_q   <= 1'b0;
      of_q   <= 1'b0;
      dout_q <= '0;
      oen_q  <= 1'b0;
    end else begin
      tcr_q  <= tcr_d;
      tcnt_q <= tcnt_d;
      tcmp_q <= tcmp_d;
      mf_q   <= mf_d;
      of_q   <= of_d;
      dout_q <= dout_d;
      oen_q  <= oen_d;
    end
  end

  assign dataOut = dout_q;
  assign outEn   = oen_q;
  assign irq     = (mf_q & tcr_q[TCR_MIE]) | (of_q & tcr_q[TCR_OIE]);

endmodule

// File: tb/tb_timer_peri.sv
// Scoreboard bench for timer_peri: directed plan plus random bus traffic
// checked against a register-level reference model.
module tb_timer_peri;

  logic        clk = 1'b0;
  logic        rstB = 1'b0;
  logic [10:0] addr = '0;
  logic [31:0] wrData = '0;
  logic        wrEn = 1'b0;
  logic        rdEn = 1'b0;
  logic [31:0] dataOut;
  logic        outEn;
  logic        irq;

  timer_peri dut (
    .clk     (clk),
    .rstB    (rstB),
    .addr    (addr),
    .wrData  (wrData),
    .wrEn    (wrEn),
    .rdEn    (rdEn),
    .dataOut (dataOut),
    .outEn   (outEn),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] A_TCR  = 11'h404;
  localparam logic [10:0] A_TCNT = 11'h405;
  localparam logic [10:0] A_TCMP = 11'h406;
  localparam logic [10:0] A_TSR  = 11'h407;

  typedef struct {
    int          cyc;
    logic [10:0] a;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_cnt = 0;
  bit   mon_on = 0;

  // Reference model state
  logic [31:0] m_tcr, m_tcnt, m_tcmp;
  bit          m_mf, m_of;
  int          m_pcnt;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic bit decoded(input logic [10:0] a);
    return a >= A_TCR && a <= A_TSR;
  endfunction

  function automatic logic [31:0] m_read(input logic [10:0] a);
    case (a)
      A_TCR:   return m_tcr;
      A_TCNT:  return m_tcnt;
      A_TCMP:  return m_tcmp;
      A_TSR:   return {30'd0, m_of, m_mf};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_irq();
    return (m_mf && m_tcr[2]) || (m_of && m_tcr[3]);
  endfunction

  // One clock edge of the timer's behaviour, from the register rules.
  task automatic m_step(input logic rb, input logic we,
                        input logic [10:0] a, input logic [31:0] d);
    int  pre;
    bit  en, tick, hit, wrapping, mf_set, of_set;
    if (!rb) begin
      m_tcr = 0; m_tcnt = 0; m_tcmp = 32'hFFFF_FFFF;
      m_mf = 0; m_of = 0; m_pcnt = 0;
      return;
    end
    pre = int'(m_tcr[15:8]);
    en  = m_tcr[0];
    if (we && a == A_TCR && !d[0]) en = 0;
    tick = en && (m_pcnt == pre);
    if (!en || m_pcnt >= pre) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;
    mf_set = 0;
    of_set = 0;
    if (we && a == A_TCNT) begin
      m_tcnt = d;
    end else if (tick) begin
      hit      = (m_tcnt == m_tcmp);
      wrapping = (m_tcnt == 32'hFFFF_FFFF);
      mf_set   = hit;
      of_set   = wrapping;
      if (hit && m_tcr[1]) m_tcnt = 0;
      else m_tcnt = 32'((longint'(m_tcnt) + 1) % 64'h1_0000_0000);
    end
    if (we && a == A_TCR)  m_tcr  = d & 32'h0000_FF0F;
    if (we && a == A_TCMP) m_tcmp = d;
    if (we && a == A_TSR && d[0]) m_mf = 0;
    if (we && a == A_TSR && d[1]) m_of = 0;
    if (mf_set) m_mf = 1;
    if (of_set) m_of = 1;
  endtask

  task automatic bus(input logic rb, input logic we, input logic re,
                     input logic [10:0] a, input logic [31:0] d);
    exp_t e;
    rstB = rb; wrEn = we; rdEn = re; addr = a; wrData = d;
    if (rb && re && decoded(a)) begin
      e.cyc = cyc_cnt + 1;
      e.a = a;
      e.data = m_read(a);
      sb.push_back(e);
    end
    @(posedge clk);
    m_step(rb, we, a, d);
    #1;
    wrEn = 0; rdEn = 0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [10:0] a);
    bus(1'b1, 1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b1, 1'b0, 1'b0, 11'h0, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      n_chk++;
      if (irq !== m_irq()) begin
        n_fail++;
        $display("FAIL irq cyc=%0d got=%b want=%b", cyc_cnt, irq, m_irq());
      end
      if (outEn === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_outEn cyc=%0d data=%h", cyc_cnt, dataOut);
        end else begin
          e = sb.pop_front();
          if (dataOut !== e.data || cyc_cnt != e.cyc) begin
            n_fail++;
            $display("FAIL read_%h cyc=%0d got=%h want=%h at cyc %0d",
                     e.a, cyc_cnt, dataOut, e.data, e.cyc);
          end
        end
      end else begin
        n_chk++;
        if (outEn !== 1'b0 || dataOut !== 32'd0) begin
          n_fail++;
          $display("FAIL idle_bus cyc=%0d outEn=%b data=%h want 0/0",
                   cyc_cnt, outEn, dataOut);
        end
        if (sb.size() != 0 && sb[0].cyc < cyc_cnt) begin
          n_chk++;
          n_fail++;
          $display("FAIL missing_outEn cyc=%0d addr=%h want=%h",
                   cyc_cnt, sb[0].a, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
  end

  function automatic logic [10:0] rnd_addr();
    int k = $urandom_range(0, 6);
    if (k == 5) return 11'h408;
    if (k == 6) return 11'h000;
    return 11'(A_TCR + 11'(k % 4));
  endfunction

  function automatic logic [31:0] rnd_data(input logic [10:0] a);
    logic [31:0] r = $urandom;
    case (a)
      A_TCR:  return {r[31:16], 8'($urandom_range(0, 3)), r[7:0]};
      A_TCNT: return ($urandom_range(0, 1) != 0)
                     ? m_tcmp - 32'($urandom_range(0, 4))
                     : 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
      A_TCMP: return ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF
                     : 32'($urandom_range(0, 12));
      default: return r;
    endcase
  endfunction

  initial begin
    m_step(1'b0, 1'b0, 11'h0, 32'd0);
    bus(1'b0, 1'b0, 1'b0, 11'h0, 32'd0);
    bus(1'b0, 1'b0, 1'b0, 11'h0, 32'd0);
    mon_on = 1;

    // Reset values and undecoded read
    rd(A_TCR); rd(A_TCNT); rd(A_TCMP); rd(A_TSR); rd(11'h408);
    idle(2);

    // Match with interrupt, then W1C
    wr(A_TCMP, 32'd5);
    wr(A_TCR, 32'h5);
    idle(7);
    rd(A_TSR); rd(A_TCNT);
    wr(A_TSR, 32'h1);
    idle(2);
    rd(A_TSR);

    // Auto-reload with PRE=3, back-to-back reads
    wr(A_TCR, 32'h0); wr(A_TSR, 32'h3);
    wr(A_TCNT, 32'h0); wr(A_TCMP, 32'd2);
    wr(A_TCR, 32'h0307);
    for (int i = 0; i < 16; i++) rd(A_TCNT);
    rd(A_TSR);

    // Overflow with OIE
    wr(A_TCR, 32'h0); wr(A_TSR, 32'h3);
    wr(A_TCMP, 32'd5);
    wr(A_TCNT, 32'hFFFF_FFFE);
    wr(A_TCR, 32'h9);
    idle(1);
    rd(A_TCNT); rd(A_TSR);

    // Collisions: TCNT write in tick cycle, W1C against a match
    wr(A_TCR, 32'h1);
    wr(A_TCNT, 32'h100);
    rd(A_TCNT);
    wr(A_TCR, 32'h0); wr(A_TSR, 32'h3);
    wr(A_TCMP, 32'h200); wr(A_TCNT, 32'h200);
    wr(A_TCR, 32'h5);
    wr(A_TSR, 32'h1);
    rd(A_TSR);

    // Reset mid-count with PRE=7
    wr(A_TCR, 32'h070D);
    wr(A_TCMP, 32'd3);
    idle(30);
    bus(1'b0, 1'b0, 1'b0, 11'h0, 32'd0);
    rd(A_TCR); rd(A_TCNT); rd(A_TCMP); rd(A_TSR);
    idle(5);
    rd(A_TCNT);
    wr(A_TCR, 32'h1);
    idle(3);
    rd(A_TCNT);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      int k;
      logic [10:0] a;
      k = $urandom_range(0, 99);
      a = rnd_addr();
      if (k == 0) bus(1'b0, 1'b0, 1'b0, 11'h0, 32'd0);
      else if (k < 30) wr(a, rnd_data(a));
      else if (k < 70) rd(a);
      else if (k < 75) bus(1'b1, 1'b1, 1'b1, a, rnd_data(a));
      else idle(1);
    end

    idle(3);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain left=%0d want=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
